// File: rtl/hazard_pkg.sv
// Shared types for the 5-stage core hazard unit and its multi-cycle scoreboard.
// Forward-select encoding, stall-cause tags and multi-cycle latency limits.
package hazard_pkg;

    localparam int MC_LAT_MAX = 15;
    localparam int MC_CNT_W   = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_LW   = 2'd1,
        ST_BR   = 2'd2,
        ST_MC   = 2'd3
    } stall_cause_t;

endpackage

// File: rtl/mc_scoreboard.sv
// Tracks the single in-flight multi-cycle write: countdown, destination,
// busy and done flags.
module mc_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [REG_AW-1:0] start_reg,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] write_reg
);

    localparam logic [MC_CNT_W-1:0] LAT = MC_CNT_W'(MC_LAT);
    localparam logic [MC_CNT_W-1:0] ONE = MC_CNT_W'(1);

    logic [MC_CNT_W-1:0] cnt;

    // A new issue reloads even when busy, so the last writer wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            write_reg <= '0;
        end else if (start) begin
            cnt       <= LAT;
            write_reg <= start_reg;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign busy = (cnt != '0);
    assign done = (cnt == ONE);

endmodule

// File: rtl/mc_hazard_unit.sv
// Hazard unit: forwarding, load-use/branch stalls and multi-cycle scoreboard.
// Optional stall-cycle counter built when HAZARD_STALL_CNT_EN is defined.
module mc_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] WriteRegD,
    input  logic              RegWriteD,
    input  logic              BranchD,
    input  logic              McOpD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              McStartE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteW,
    output fwd_sel_t          ForwardAE,
    output fwd_sel_t          ForwardBE,
    output fwd_sel_t          ForwardCE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              McBusy,
    output logic              McDone,
    output logic [REG_AW-1:0] McWriteReg,
    output logic [CNT_W-1:0]  StallCyc
);

    logic lwstall;
    logic brstall;
    logic mcstall;
    logic stall;

    function automatic logic hit(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dst,
        input logic              we
    );
        return we && (dst != '0) && (src == dst);
    endfunction

    // M wins over W: it holds the younger result.
    function automatic fwd_sel_t fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wr_m,
        input logic              we_m,
        input logic [REG_AW-1:0] wr_w,
        input logic              we_w
    );
        if (hit(src, wr_m, we_m))
            return FWD_MEM;
        else if (hit(src, wr_w, we_w))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign ForwardAE = fwd_sel(rsE, WriteRegM, RegWriteM,
                               WriteRegW, RegWriteW);
    assign ForwardBE = fwd_sel(rtE, WriteRegM, RegWriteM,
                               WriteRegW, RegWriteW);
    assign ForwardCE = fwd_sel(rdE, WriteRegM, RegWriteM,
                               WriteRegW, RegWriteW);

    assign ForwardAD = hit(rsD, WriteRegM, RegWriteM);
    assign ForwardBD = hit(rtD, WriteRegM, RegWriteM);

    assign lwstall = MemtoRegE && (rtE != '0)
                   && ((rsD == rtE) || (rtD == rtE));

    assign brstall = BranchD
        && (hit(rsD, WriteRegE, RegWriteE)
         || hit(rtD, WriteRegE, RegWriteE)
         || hit(rsD, WriteRegM, MemtoRegM)
         || hit(rtD, WriteRegM, MemtoRegM));

    // Structural on McOpD; RAW/WAW only against a non-zero destination.
    assign mcstall = McBusy
        && (McOpD
         || ((McWriteReg != '0)
          && ((rsD == McWriteReg)
           || (rtD == McWriteReg)
           || (RegWriteD && (WriteRegD == McWriteReg)))));

    assign stall  = lwstall || brstall || mcstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    mc_scoreboard #(
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .start     (McStartE),
        .start_reg (WriteRegE),
        .busy      (McBusy),
        .done      (McDone),
        .write_reg (McWriteReg)
    );

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (StallD && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign StallCyc = stall_cnt;
`else
    assign StallCyc = '0;
`endif

endmodule

// File: tb/tb_mc_hazard_unit.sv
// Scoreboard bench for mc_hazard_unit: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_mc_hazard_unit;
    import hazard_pkg::*;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] rsD, rtD, wrD;
        logic          rwD, brD, mcD;
        logic [AW-1:0] rsE, rtE, rdE, wrE;
        logic          rwE, m2rE, mcsE;
        logic [AW-1:0] wrM;
        logic          rwM, m2rM;
        logic [AW-1:0] wrW;
        logic          rwW;
    } in_t;

    typedef struct packed {
        logic [1:0]    fa, fb, fc;
        logic          fad, fbd, st, busy, done;
        logic [AW-1:0] mwr;
        logic [CW-1:0] sc;
    } exp_t;

    in_t d;

    fwd_sel_t      ForwardAE, ForwardBE, ForwardCE;
    logic          ForwardAD, ForwardBD;
    logic          StallF, StallD, FlushE;
    logic          McBusy, McDone;
    logic [AW-1:0] McWriteReg;
    logic [CW-1:0] StallCyc;

    mc_hazard_unit #(
        .REG_AW (AW),
        .MC_LAT (LAT),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rsD        (d.rsD),
        .rtD        (d.rtD),
        .WriteRegD  (d.wrD),
        .RegWriteD  (d.rwD),
        .BranchD    (d.brD),
        .McOpD      (d.mcD),
        .rsE        (d.rsE),
        .rtE        (d.rtE),
        .rdE        (d.rdE),
        .WriteRegE  (d.wrE),
        .RegWriteE  (d.rwE),
        .MemtoRegE  (d.m2rE),
        .McStartE   (d.mcsE),
        .WriteRegM  (d.wrM),
        .RegWriteM  (d.rwM),
        .MemtoRegM  (d.m2rM),
        .WriteRegW  (d.wrW),
        .RegWriteW  (d.rwW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ForwardCE  (ForwardCE),
        .ForwardAD  (ForwardAD),
        .ForwardBD  (ForwardBD),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushE     (FlushE),
        .McBusy     (McBusy),
        .McDone     (McDone),
        .McWriteReg (McWriteReg),
        .StallCyc   (StallCyc)
    );

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad   = 0;
    logic [CW-1:0] acc = '0;

    task automatic vec(input string n,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [1:0] fc,
                       input logic fad, input logic fbd, input logic st,
                       input logic busy, input logic done,
                       input logic [AW-1:0] mwr);
        exp_t e;
        e.fa = fa; e.fb = fb; e.fc = fc;
        e.fad = fad; e.fbd = fbd; e.st = st;
        e.busy = busy; e.done = done; e.mwr = mwr;
        if (!reset) acc = '0;
`ifdef HAZARD_STALL_CNT_EN
        e.sc = acc;
`else
        e.sc = '0;
`endif
        if (reset && st) acc = acc + 1;
        q.push_back(e);
        nq.push_back(n);
        @(posedge clk);
        #1;
    endtask

    exp_t        ce;
    string       cn;
    logic [7:0]  af, ef;
    logic [9:0]  as, es;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            cn = nq.pop_front();
            af = {ForwardAE, ForwardBE, ForwardCE, ForwardAD, ForwardBD};
            ef = {ce.fa, ce.fb, ce.fc, ce.fad, ce.fbd};
            total++;
            if (af !== ef) begin
                bad++;
                $display("FAIL %s fwd: got %b want %b", cn, af, ef);
            end
            as = {StallF, StallD, FlushE, McBusy, McDone, McWriteReg};
            es = {ce.st, ce.st, ce.st, ce.busy, ce.done, ce.mwr};
            total++;
            if (as !== es) begin
                bad++;
                $display("FAIL %s stall/sb: got %b want %b", cn, as, es);
            end
            total++;
            if (StallCyc !== ce.sc) begin
                bad++;
                $display("FAIL %s stallcyc: got %0d want %0d",
                         cn, StallCyc, ce.sc);
            end
        end
    end

    // An issue while busy means the D-stage interlock failed.
    always @(posedge clk) begin
        if (reset === 1'b1 && d.mcsE && McBusy) begin
            bad++;
            $display("FAIL mc_issue_busy: got McStartE=1 McBusy=1 want no overlap");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        d = '0;
        @(posedge clk);
        #1;
        vec("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        vec("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        d = '0; d.wrM = 8; d.rwM = 1; d.wrW = 8; d.rwW = 1;
        d.rsE = 8; d.rtE = 3; d.rdE = 8;
        vec("m_prio", 2, 0, 2, 0, 0, 0, 0, 0, 0);
        d = '0; d.wrM = 9; d.rwM = 1; d.wrW = 8; d.rwW = 1;
        d.rsE = 4; d.rtE = 8; d.rdE = 9;
        vec("wb_fwd", 0, 1, 2, 0, 0, 0, 0, 0, 0);
        d = '0; d.rwM = 1; d.rwW = 1;
        vec("r0_nofwd", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        d = '0; d.wrM = 7; d.rsE = 7; d.rsD = 7;
        vec("no_we", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        d = '0; d.m2rE = 1; d.rwE = 1; d.wrE = 9; d.rtE = 9; d.rsE = 2;
        d.rsD = 1; d.rtD = 9;
        vec("lw_use", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        d = '0; d.wrM = 9; d.rwM = 1; d.m2rM = 1; d.rsD = 1; d.rtD = 9;
        vec("lw_bubble", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        d = '0; d.wrW = 9; d.rwW = 1; d.rsE = 1; d.rtE = 9;
        vec("lw_fwd", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        d = '0; d.m2rE = 1; d.rwE = 1;
        vec("lw_r0", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        d = '0; d.brD = 1; d.rsD = 10; d.rtD = 11; d.rwE = 1; d.wrE = 10;
        vec("br_e", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        d = '0; d.brD = 1; d.rsD = 10; d.rtD = 11; d.wrM = 10; d.rwM = 1;
        vec("br_fwd", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        d = '0; d.brD = 1; d.rsD = 3; d.rtD = 10;
        d.wrM = 10; d.rwM = 1; d.m2rM = 1;
        vec("br_lw_m", 0, 0, 0, 0, 1, 1, 0, 0, 0);

        d = '0; d.mcsE = 1; d.wrE = 12;
        vec("mc_issue", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        d = '0; d.rsD = 12;
        for (int i = 1; i <= LAT; i++)
            vec("mc_raw", 0, 0, 0, 0, 0, 1, 1, (i == LAT), 12);
        vec("mc_go", 0, 0, 0, 0, 0, 0, 0, 0, 12);

        d = '0; d.mcsE = 1; d.wrE = 12;
        vec("mc_issue2", 0, 0, 0, 0, 0, 0, 0, 0, 12);
        d = '0; d.mcD = 1; d.rsD = 1; d.rtD = 2;
        vec("mc_struct", 0, 0, 0, 0, 0, 1, 1, 0, 12);
        d = '0; d.rwD = 1; d.wrD = 12;
        vec("mc_waw", 0, 0, 0, 0, 0, 1, 1, 0, 12);
        d = '0; d.rwD = 1; d.wrD = 13; d.rsD = 3;
        vec("mc_indep", 0, 0, 0, 0, 0, 0, 1, 0, 12);
        d = '0; d.mcD = 1;
        vec("mc_struct_done", 0, 0, 0, 0, 0, 1, 1, 1, 12);
        vec("mc_free", 0, 0, 0, 0, 0, 0, 0, 0, 12);

        d = '0; d.mcsE = 1;
        vec("mc_issue_r0", 0, 0, 0, 0, 0, 0, 0, 0, 12);
        d = '0; d.rwD = 1;
        vec("mc_r0_nodep", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        d = '0; d.mcD = 1;
        vec("mc_r0_struct", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        d = '0;
        vec("mc_r0_idle", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vec("mc_r0_done", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        vec("mc_r0_end", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        d = '0; d.mcsE = 1; d.wrE = 12;
        vec("mc_issue3", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        d = '0; d.rsD = 12;
        vec("mc_pre_rst", 0, 0, 0, 0, 0, 1, 1, 0, 12);
        reset = 1'b0;
        vec("mc_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        d = '0;
        vec("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
